// File: rtl/hsv_dmem_axil_ram_if.sv
// AXI4-Lite bundle between the core's dmem master and its data RAM.
// Modport s: the RAM side (drives ready/response channels); modport m: the core side.
// Channels: AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready),
//           AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready), B (bresp/bvalid/bready).
interface axil_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport s (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport m (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/hsv_dmem_axil_ram.sv
// AXI4-Lite slave data RAM: single-port word array, independent read and write flows, SLVERR out of range.
// Latency: AR->R 2 cycles, last of AW/W -> B 2 cycles; a read/write collision on the array costs the loser 1 cycle.
// Backpressure: R/B hold until rready/bready; readies come only from registered state (one read, one write held).
// Ports: clk_core, rst_core_n (async, active-low), dmem (axil_if.s slave modport).
module hsv_dmem_axil_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    dmem
);

  localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One past the last byte, widened so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIM = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Full-width compare; BASE_ADDR is window-aligned so low address bits double as the index.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIM);
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        r_rd_busy;
  logic [31:0] r_ar_addr;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        r_aw_held;
  logic [31:0] r_aw_addr;
  logic        r_w_held;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;

  // 0 = read won the last collision, 1 = write won it.
  logic        r_last_grant;

  logic          w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic          w_rd_req, w_wr_req, w_conflict, w_rd_go, w_wr_go;
  logic          w_rd_in, w_wr_in;
  logic [AW-1:0] w_rd_idx, w_wr_idx;

  assign w_ar_hs = dmem.arvalid & ~r_rd_busy;
  assign w_r_hs  = r_rvalid & dmem.rready;
  assign w_aw_hs = dmem.awvalid & ~r_aw_held;
  assign w_w_hs  = dmem.wvalid & ~r_w_held;
  assign w_b_hs  = r_bvalid & dmem.bready;

  // A read is pending from the cycle after AR until its data is registered.
  assign w_rd_req   = r_rd_busy & ~r_rvalid;
  // A complete write waits for the previous B to retire before touching the array.
  assign w_wr_req   = r_aw_held & r_w_held & ~r_bvalid;
  assign w_conflict = w_rd_req & w_wr_req;
  assign w_rd_go    = w_rd_req & (~w_wr_req | r_last_grant);
  assign w_wr_go    = w_wr_req & (~w_rd_req | ~r_last_grant);

  assign w_rd_in  = in_range(r_ar_addr);
  assign w_wr_in  = in_range(r_aw_addr);
  assign w_rd_idx = r_ar_addr[AW+1:2];
  assign w_wr_idx = r_aw_addr[AW+1:2];

  assign dmem.arready = ~r_rd_busy;
  assign dmem.rvalid  = r_rvalid;
  assign dmem.rdata   = r_rdata;
  assign dmem.rresp   = r_rresp;
  assign dmem.awready = ~r_aw_held;
  assign dmem.wready  = ~r_w_held;
  assign dmem.bvalid  = r_bvalid;
  assign dmem.bresp   = r_bresp;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_rd_busy    <= 1'b0;
      r_ar_addr    <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_aw_held    <= 1'b0;
      r_aw_addr    <= '0;
      r_w_held     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_last_grant <= 1'b0;
    end else begin
      // Read channel
      if (w_ar_hs) begin
        r_rd_busy <= 1'b1;
        r_ar_addr <= dmem.araddr;
      end else if (w_r_hs) begin
        r_rd_busy <= 1'b0;
      end

      if (w_rd_go) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
        r_rdata  <= w_rd_in ? r_mem[w_rd_idx] : 32'h0;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end

      // Write address / data capture, freed when the write executes
      if (w_wr_go) begin
        r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= dmem.awaddr;
      end

      if (w_wr_go) begin
        r_w_held <= 1'b0;
      end else if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= dmem.wdata;
        r_wstrb  <= dmem.wstrb;
      end

      if (w_wr_go) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end

      if (w_conflict) begin
        r_last_grant <= w_wr_go;
      end
    end
  end

  // Array contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk_core) begin
    if (w_wr_go && w_wr_in) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_dmem_axil_ram.sv
module tb_hsv_dmem_axil_ram;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] OOR   = BASE + 32'd64;

  logic clk_core;
  logic rst_core_n;
  int   n_chk;
  int   n_err;

  axil_if dmem_if ();

  hsv_dmem_axil_ram #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .dmem      (dmem_if)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    dmem_if.awaddr  = a;
    dmem_if.awvalid = 1'b1;
    dmem_if.wdata   = d;
    dmem_if.wstrb   = s;
    dmem_if.wvalid  = 1'b1;
    tick();
    dmem_if.awvalid = 1'b0;
    dmem_if.wvalid  = 1'b0;
    lat = 1;
    while (dmem_if.bvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    resp = dmem_if.bresp;
    dmem_if.bready = 1'b1;
    tick();
    dmem_if.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    dmem_if.araddr  = a;
    dmem_if.arvalid = 1'b1;
    tick();
    dmem_if.arvalid = 1'b0;
    lat = 1;
    while (dmem_if.rvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d    = dmem_if.rdata;
    resp = dmem_if.rresp;
    dmem_if.rready = 1'b1;
    tick();
    dmem_if.rready = 1'b0;
  endtask

  task automatic do_reset();
    rst_core_n = 1'b0;
    tick();
    tick();
    rst_core_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;

    n_chk = 0;
    n_err = 0;
    rst_core_n      = 1'b1;
    dmem_if.araddr  = '0;
    dmem_if.arvalid = 1'b0;
    dmem_if.rready  = 1'b0;
    dmem_if.awaddr  = '0;
    dmem_if.awvalid = 1'b0;
    dmem_if.wdata   = '0;
    dmem_if.wstrb   = '0;
    dmem_if.wvalid  = 1'b0;
    dmem_if.bready  = 1'b0;
    #2;

    // Reset values
    do_reset();
    chk("rst_arready", 32'(dmem_if.arready), 32'd1);
    chk("rst_awready", 32'(dmem_if.awready), 32'd1);
    chk("rst_wready",  32'(dmem_if.wready),  32'd1);
    chk("rst_rvalid",  32'(dmem_if.rvalid),  32'd0);
    chk("rst_bvalid",  32'(dmem_if.bvalid),  32'd0);
    chk("rst_rdata",   dmem_if.rdata,        32'd0);
    chk("rst_rresp",   32'(dmem_if.rresp),   32'd0);
    chk("rst_bresp",   32'(dmem_if.bresp),   32'd0);

    // Conflict straight after reset: AR, AW and W all in the same cycle, same address.
    dmem_if.araddr  = BASE + 32'h3C;
    dmem_if.arvalid = 1'b1;
    dmem_if.awaddr  = BASE + 32'h3C;
    dmem_if.awvalid = 1'b1;
    dmem_if.wdata   = 32'h5A5A_1234;
    dmem_if.wstrb   = 4'hF;
    dmem_if.wvalid  = 1'b1;
    tick();
    dmem_if.arvalid = 1'b0;
    dmem_if.awvalid = 1'b0;
    dmem_if.wvalid  = 1'b0;
    chk("cf_arready_busy", 32'(dmem_if.arready), 32'd0);
    chk("cf_awready_held", 32'(dmem_if.awready), 32'd0);
    tick();
    chk("cf_bvalid_first", 32'(dmem_if.bvalid), 32'd1);
    chk("cf_rvalid_late",  32'(dmem_if.rvalid), 32'd0);
    tick();
    chk("cf_rvalid",  32'(dmem_if.rvalid), 32'd1);
    chk("cf_rdata",   dmem_if.rdata,       32'h5A5A_1234);
    chk("cf_rresp",   32'(dmem_if.rresp),  32'd0);

    // Hold both responses; offer a second write that must be held but not executed.
    dmem_if.awaddr  = BASE + 32'h3C;
    dmem_if.awvalid = 1'b1;
    dmem_if.wdata   = 32'hFFFF_0000;
    dmem_if.wstrb   = 4'hF;
    dmem_if.wvalid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      dmem_if.awvalid = 1'b0;
      dmem_if.wvalid  = 1'b0;
      chk($sformatf("bp_rvalid_%0d", i),  32'(dmem_if.rvalid),  32'd1);
      chk($sformatf("bp_bvalid_%0d", i),  32'(dmem_if.bvalid),  32'd1);
      chk($sformatf("bp_rdata_%0d", i),   dmem_if.rdata,        32'h5A5A_1234);
      chk($sformatf("bp_bresp_%0d", i),   32'(dmem_if.bresp),   32'd0);
      chk($sformatf("bp_arready_%0d", i), 32'(dmem_if.arready), 32'd0);
    end
    chk("bp_awready_second_held", 32'(dmem_if.awready), 32'd0);

    // Asynchronous reset in the middle of the hold
    rst_core_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(dmem_if.rvalid), 32'd0);
    chk("arst_bvalid", 32'(dmem_if.bvalid), 32'd0);
    tick();
    rst_core_n = 1'b1;
    tick();
    chk("arst_arready", 32'(dmem_if.arready), 32'd1);
    chk("arst_awready", 32'(dmem_if.awready), 32'd1);
    chk("arst_wready",  32'(dmem_if.wready),  32'd1);
    // First write retained; the held second write was discarded.
    do_read(BASE + 32'h3C, rd, rs, lat);
    chk("arst_retained", rd, 32'h5A5A_1234);

    // Basic write then read
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rs, lat);
    chk("wr_lat",  32'(lat), 32'd2);
    chk("wr_resp", 32'(rs),  32'd0);
    do_read(BASE + 32'h10, rd, rs, lat);
    chk("rd_lat",   32'(lat), 32'd2);
    chk("rd_data",  rd,       32'hDEAD_BEEF);
    chk("rd_resp",  32'(rs),  32'd0);
    chk("rd_arready_after", 32'(dmem_if.arready), 32'd1);

    // Partial strobe
    do_write(BASE + 32'h20, 32'h1122_3344, 4'hF, rs, lat);
    do_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, rs, lat);
    chk("ps_resp", 32'(rs), 32'd0);
    do_read(BASE + 32'h20, rd, rs, lat);
    chk("ps_data", rd, 32'h11BB_33DD);

    // W three cycles ahead of AW
    dmem_if.wdata  = 32'hCAFE_F00D;
    dmem_if.wstrb  = 4'hF;
    dmem_if.wvalid = 1'b1;
    tick();
    dmem_if.wvalid = 1'b0;
    chk("wf_wready_drop", 32'(dmem_if.wready),  32'd0);
    chk("wf_awready",     32'(dmem_if.awready), 32'd1);
    tick();
    chk("wf_no_bvalid", 32'(dmem_if.bvalid), 32'd0);
    tick();
    dmem_if.awaddr  = BASE + 32'h30;
    dmem_if.awvalid = 1'b1;
    tick();
    dmem_if.awvalid = 1'b0;
    chk("wf_bvalid_n1", 32'(dmem_if.bvalid), 32'd0);
    tick();
    chk("wf_bvalid_n2", 32'(dmem_if.bvalid), 32'd1);
    chk("wf_bresp",     32'(dmem_if.bresp),  32'd0);
    dmem_if.bready = 1'b1;
    tick();
    dmem_if.bready = 1'b0;
    chk("wf_bvalid_clr", 32'(dmem_if.bvalid), 32'd0);
    do_read(BASE + 32'h30, rd, rs, lat);
    chk("wf_data", rd, 32'hCAFE_F00D);

    // Out of range: index bits alias word 0, which must stay untouched
    do_write(BASE, 32'h0BAD_F00D, 4'hF, rs, lat);
    do_write(OOR, 32'h1234_5678, 4'hF, rs, lat);
    chk("oor_wr_lat",  32'(lat), 32'd2);
    chk("oor_wr_resp", 32'(rs),  32'd2);
    do_read(OOR, rd, rs, lat);
    chk("oor_rd_lat",  32'(lat), 32'd2);
    chk("oor_rd_resp", 32'(rs),  32'd2);
    chk("oor_rd_data", rd,       32'd0);
    do_read(BASE, rd, rs, lat);
    chk("oor_word0_kept", rd, 32'h0BAD_F00D);
    chk("oor_word0_resp", 32'(rs), 32'd0);
    do_read(BASE - 32'd4, rd, rs, lat);
    chk("below_base_resp", 32'(rs), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
